// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master engine.
// One holding register, one receive register, four CPOL/CPHA modes.
module spi_master_param #(
   parameter  int DW     = 8,
   parameter  int NUM_CS = 4,
   parameter  int DIV_W  = 8,
   localparam int SW     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              WRITE,
   input  logic [DW-1:0]     INCOMING_DATA,
   input  logic [SW-1:0]     CS_SEL,
   input  logic              READ,
   output logic [DW-1:0]     OUTCOMING_DATA,
   input  logic              CPOL,
   input  logic              CPHA,
   input  logic              LSB_FIRST,
   input  logic [DIV_W-1:0]  DIV,
   output logic              S_CLK,
   output logic              OUT,
   input  logic              IN,
   output logic [NUM_CS-1:0] CS,
   output logic              BUSY,
   output logic              TX_FULL,
   output logic              RX_FULL,
   output logic              OVERRUN
);

   localparam int EW = $clog2(2 * DW + 1);
   localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DW);
   localparam logic [EW-1:0] EDGE_ONE  = EW'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_XFER  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]        r_state;
   logic [DIV_W-1:0]  r_cnt;
   logic [DIV_W-1:0]  r_div;
   logic [EW-1:0]     r_edge;
   logic              r_cpol;
   logic              r_cpha;
   logic              r_lsb;
   logic [DW-1:0]     r_tx;
   logic [DW-1:0]     r_rx;
   logic [DW-1:0]     r_hold;
   logic [DW-1:0]     r_data;
   logic [SW-1:0]     r_hold_sel;
   logic [SW-1:0]     r_sel;
   logic              r_tx_full;
   logic              r_rx_full;
   logic              r_ovr;
   logic              r_sclk;
   logic              r_out;
   logic              r_busy;
   logic [NUM_CS-1:0] r_cs;

   logic              w_half_end;
   logic              w_load;
   logic              w_tick;
   logic              w_odd;
   logic              w_sample;
   logic              w_drive;
   logic              w_done;
   logic              w_bit_next;
   logic              w_first;
   logic [EW-1:0]     w_edge_n;
   logic [DW-1:0]     w_rx_next;
   logic [DW-1:0]     w_tx_next;
   logic [NUM_CS-1:0] w_cs_dec;

   assign w_half_end = (r_cnt == r_div);
   assign w_edge_n   = r_edge + EW'(1);
   assign w_odd      = w_edge_n[0];
   assign w_tick     = (r_state == S_XFER) && w_half_end;
   assign w_sample   = w_tick && (r_cpha ? !w_odd : w_odd);
   assign w_drive    = w_tick && (r_cpha ?
                       (w_odd && (w_edge_n != EDGE_ONE)) :
                       (!w_odd && (w_edge_n != EDGE_LAST)));
   assign w_done     = w_tick && (w_edge_n == EDGE_LAST);

   // A chained word must target the select that is already low
   assign w_load = r_tx_full && ((r_state == S_IDLE) ||
                   ((r_state == S_HOLD) && w_half_end &&
                    (r_hold_sel == r_sel)));

   assign w_rx_next  = r_lsb ? {IN, r_rx[DW-1:1]} : {r_rx[DW-2:0], IN};
   assign w_tx_next  = r_lsb ? {1'b0, r_tx[DW-1:1]} : {r_tx[DW-2:0], 1'b0};
   assign w_bit_next = r_lsb ? r_tx[1] : r_tx[DW-2];
   assign w_first    = LSB_FIRST ? r_hold[0] : r_hold[DW-1];

   // Decode the held select; out-of-range indices leave every line high
   always_comb begin
      w_cs_dec = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (r_hold_sel == SW'(i)) w_cs_dec[i] = 1'b0;
      end
   end

   // Transfer sequencer: state, bit timing, shift registers and pins
   always_ff @(posedge CLK) begin
      if (CLR) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_div   <= '0;
         r_edge  <= '0;
         r_cpol  <= 1'b0;
         r_cpha  <= 1'b0;
         r_lsb   <= 1'b0;
         r_tx    <= '0;
         r_rx    <= '0;
         r_sel   <= '0;
         r_sclk  <= 1'b0;
         r_out   <= 1'b0;
         r_busy  <= 1'b0;
         r_cs    <= '1;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_sclk <= CPOL;
               r_cs   <= '1;
            end
            S_SETUP: begin
               r_cnt <= w_half_end ? '0 : r_cnt + DIV_W'(1);
               if (w_half_end) begin
                  r_state <= S_XFER;
                  r_edge  <= '0;
               end
            end
            S_XFER: begin
               r_cnt <= w_half_end ? '0 : r_cnt + DIV_W'(1);
               if (w_half_end) begin
                  r_sclk <= ~r_sclk;
                  r_edge <= w_edge_n;
                  if (w_sample) r_rx <= w_rx_next;
                  if (w_drive) begin
                     r_tx  <= w_tx_next;
                     r_out <= w_bit_next;
                  end
                  if (w_done) r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               r_sclk <= r_cpol;
               r_cnt  <= w_half_end ? '0 : r_cnt + DIV_W'(1);
               if (w_half_end) begin
                  r_state <= S_IDLE;
                  r_cs    <= '1;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_load) begin
            r_state <= S_SETUP;
            r_cnt   <= '0;
            r_edge  <= '0;
            r_div   <= DIV;
            r_cpol  <= CPOL;
            r_cpha  <= CPHA;
            r_lsb   <= LSB_FIRST;
            r_tx    <= r_hold;
            r_rx    <= '0;
            r_sel   <= r_hold_sel;
            r_cs    <= w_cs_dec;
            r_busy  <= 1'b1;
            r_sclk  <= CPOL;
            r_out   <= w_first;
         end
      end
   end

   // Host holding register: one word deep, writes while full are dropped
   always_ff @(posedge CLK) begin
      if (CLR) begin
         r_hold     <= '0;
         r_hold_sel <= '0;
         r_tx_full  <= 1'b0;
      end else if (w_load) begin
         r_tx_full  <= 1'b0;
      end else if (WRITE && !r_tx_full) begin
         r_hold     <= INCOMING_DATA;
         r_hold_sel <= CS_SEL;
         r_tx_full  <= 1'b1;
      end
   end

   // Receive register with sticky overrun; a same-cycle read absorbs it
   always_ff @(posedge CLK) begin
      if (CLR) begin
         r_data    <= '0;
         r_rx_full <= 1'b0;
         r_ovr     <= 1'b0;
      end else if (w_done) begin
         r_data    <= r_cpha ? w_rx_next : r_rx;
         r_rx_full <= 1'b1;
         if (r_rx_full && !READ) r_ovr <= 1'b1;
         else if (READ) r_ovr <= 1'b0;
      end else if (READ) begin
         r_rx_full <= 1'b0;
         r_ovr     <= 1'b0;
      end
   end

   assign OUTCOMING_DATA = r_data;
   assign S_CLK          = r_sclk;
   assign OUT            = r_out;
   assign CS             = r_cs;
   assign BUSY           = r_busy;
   assign TX_FULL        = r_tx_full;
   assign RX_FULL        = r_rx_full;
   assign OVERRUN        = r_ovr;

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: randomised and directed bench for spi_master_param.
// Expected values come from a word-level model of the SPI frame.
module tb_spi_master_param;

   logic       CLK;
   logic       CLR;
   logic       WRITE;
   logic [7:0] INCOMING_DATA;
   logic [1:0] CS_SEL;
   logic       READ;
   logic [7:0] OUTCOMING_DATA;
   logic       CPOL;
   logic       CPHA;
   logic       LSB_FIRST;
   logic [7:0] DIV;
   logic       S_CLK;
   logic       OUT;
   logic       IN;
   logic [3:0] CS;
   logic       BUSY;
   logic       TX_FULL;
   logic       RX_FULL;
   logic       OVERRUN;

   logic loopb;
   logic in_drv;
   assign IN = loopb ? OUT : in_drv;

   int errors = 0;
   int checks = 0;

   int          m_low;
   int          m_edges;
   int          m_nsamp;
   int          m_fall;
   int          m_rx;
   int          m_rises;
   int          m_gap;
   logic [3:0]  m_cs;
   logic [15:0] m_outs;

   spi_master_param #(.DW(8), .NUM_CS(4), .DIV_W(8)) dut (
      .CLK(CLK), .CLR(CLR), .WRITE(WRITE),
      .INCOMING_DATA(INCOMING_DATA), .CS_SEL(CS_SEL), .READ(READ),
      .OUTCOMING_DATA(OUTCOMING_DATA), .CPOL(CPOL), .CPHA(CPHA),
      .LSB_FIRST(LSB_FIRST), .DIV(DIV), .S_CLK(S_CLK), .OUT(OUT),
      .IN(IN), .CS(CS), .BUSY(BUSY), .TX_FULL(TX_FULL),
      .RX_FULL(RX_FULL), .OVERRUN(OVERRUN)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic write_word(input logic [7:0] d, input logic [1:0] s);
      @(negedge CLK);
      WRITE = 1'b1;
      INCOMING_DATA = d;
      CS_SEL = s;
      @(negedge CLK);
      WRITE = 1'b0;
   endtask

   // Sets the mode, acknowledges any pending word and lets S_CLK settle
   task automatic set_mode(input logic pol, input logic pha,
                           input logic lsb, input logic [7:0] dv);
      @(negedge CLK);
      CPOL = pol;
      CPHA = pha;
      LSB_FIRST = lsb;
      DIV = dv;
      READ = 1'b1;
      @(negedge CLK);
      READ = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   // Pin observer: records frame timing and the bit on each sample edge
   task automatic watch(input int ncyc, input logic pha,
                        input logic rnd_in, input logic [7:0] in_bits);
      logic pk;
      logic was_low;
      logic rx_prev;
      int   hi_run;
      m_low = 0; m_edges = 0; m_nsamp = 0; m_fall = -1; m_rx = -1;
      m_rises = 0; m_gap = 0; m_cs = 4'hF; m_outs = '0;
      pk = S_CLK; was_low = 1'b0; rx_prev = RX_FULL; hi_run = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge CLK);
         if (CS != 4'hF) begin
            m_low++;
            if (m_fall < 0) begin
               m_fall = c;
               m_cs = CS;
            end
            if (m_rises == 1 && m_gap == 0) m_gap = hi_run;
            was_low = 1'b1;
         end else begin
            if (was_low) m_rises++;
            was_low = 1'b0;
            if (m_rises == 1) hi_run++;
         end
         if (BUSY && S_CLK !== pk) begin
            m_edges++;
            if (pha ? (m_edges % 2 == 0) : (m_edges % 2 == 1)) begin
               if (m_nsamp < 16) m_outs[m_nsamp] = OUT;
               m_nsamp++;
               if (rnd_in && m_nsamp < 8) in_drv = in_bits[m_nsamp];
            end
         end
         pk = S_CLK;
         if (RX_FULL && !rx_prev && m_rx < 0) m_rx = c;
         rx_prev = RX_FULL;
      end
   endtask

   task automatic test_reset;
      CLR = 1'b1;
      repeat (3) @(negedge CLK);
      checks++;
      if (CS !== 4'hF) begin
         errors++; $display("FAIL reset_cs got=%h exp=f", CS);
      end
      checks++;
      if ({S_CLK, OUT} !== 2'b00) begin
         errors++; $display("FAIL reset_pins got=%b exp=00", {S_CLK, OUT});
      end
      checks++;
      if (OUTCOMING_DATA !== 8'h00) begin
         errors++; $display("FAIL reset_data got=%h exp=00", OUTCOMING_DATA);
      end
      checks++;
      if ({BUSY, TX_FULL, RX_FULL, OVERRUN} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_status got=%b exp=0000",
                  {BUSY, TX_FULL, RX_FULL, OVERRUN});
      end
      @(negedge CLK);
      CLR = 1'b0;
   endtask

   task automatic test_basic;
      set_mode(1'b0, 1'b0, 1'b0, 8'd1);
      loopb = 1'b1;
      write_word(8'hA5, 2'd2);
      watch(44, 1'b0, 1'b0, 8'h00);
      checks++;
      if (m_cs !== 4'b1011) begin
         errors++; $display("FAIL basic_cs got=%b exp=1011", m_cs);
      end
      checks++;
      if (m_low != 36) begin
         errors++; $display("FAIL basic_cs_len got=%0d exp=36", m_low);
      end
      checks++;
      if (m_edges != 16) begin
         errors++; $display("FAIL basic_edges got=%0d exp=16", m_edges);
      end
      checks++;
      if (OUTCOMING_DATA !== 8'hA5 || RX_FULL !== 1'b1) begin
         errors++;
         $display("FAIL basic_rx got=%h/%b exp=a5/1", OUTCOMING_DATA, RX_FULL);
      end
      checks++;
      if (m_rx - m_fall != 34) begin
         errors++; $display("FAIL basic_rx_lat got=%0d exp=34", m_rx - m_fall);
      end
   endtask

   task automatic test_mode3;
      logic [7:0] seq;
      set_mode(1'b1, 1'b1, 1'b1, 8'd0);
      loopb = 1'b0;
      in_drv = 1'b1;
      checks++;
      if (S_CLK !== 1'b1) begin
         errors++; $display("FAIL m3_idle got=%b exp=1", S_CLK);
      end
      write_word(8'h3C, 2'd0);
      watch(26, 1'b1, 1'b0, 8'h00);
      seq = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      checks++;
      if (m_outs[7:0] !== seq) begin
         errors++; $display("FAIL m3_out got=%b exp=%b", m_outs[7:0], seq);
      end
      checks++;
      if (OUTCOMING_DATA !== 8'hFF) begin
         errors++; $display("FAIL m3_rx got=%h exp=ff", OUTCOMING_DATA);
      end
      checks++;
      if (S_CLK !== 1'b1 || m_low != 18) begin
         errors++;
         $display("FAIL m3_end got=%b/%0d exp=1/18", S_CLK, m_low);
      end
   endtask

   task automatic test_random;
      logic       pol, pha, lsb;
      logic [7:0] dv, d, inb, exp_out, exp_rx;
      logic [1:0] sel;
      int         h;
      for (int it = 0; it < 8; it++) begin
         pol = 1'($urandom_range(0, 1));
         pha = 1'($urandom_range(0, 1));
         lsb = 1'($urandom_range(0, 1));
         dv  = 8'($urandom_range(0, 3));
         sel = 2'($urandom_range(0, 3));
         d   = 8'($urandom);
         inb = 8'($urandom);
         h   = int'(dv) + 1;
         for (int j = 0; j < 8; j++) begin
            exp_out[j] = lsb ? d[j] : d[7-j];
            exp_rx[lsb ? j : 7 - j] = inb[j];
         end
         set_mode(pol, pha, lsb, dv);
         checks++;
         if (S_CLK !== pol) begin
            errors++; $display("FAIL rnd%0d_idle got=%b exp=%b", it, S_CLK, pol);
         end
         loopb = 1'b0;
         in_drv = inb[0];
         write_word(d, sel);
         fork
            watch(18 * h + 6, pha, 1'b1, inb);
            begin
               repeat (4) @(negedge CLK);
               CPOL = 1'($urandom_range(0, 1));
               CPHA = 1'($urandom_range(0, 1));
               LSB_FIRST = 1'($urandom_range(0, 1));
               DIV = 8'($urandom_range(0, 3));
            end
         join
         checks++;
         if (m_cs !== ~(4'b0001 << sel) || m_low != 18 * h) begin
            errors++;
            $display("FAIL rnd%0d_cs got=%b/%0d exp=%b/%0d", it, m_cs, m_low,
                     ~(4'b0001 << sel), 18 * h);
         end
         checks++;
         if (m_edges != 16 || m_nsamp != 8) begin
            errors++;
            $display("FAIL rnd%0d_edges got=%0d/%0d exp=16/8", it, m_edges, m_nsamp);
         end
         checks++;
         if (m_outs[7:0] !== exp_out) begin
            errors++;
            $display("FAIL rnd%0d_out got=%b exp=%b", it, m_outs[7:0], exp_out);
         end
         checks++;
         if (OUTCOMING_DATA !== exp_rx) begin
            errors++;
            $display("FAIL rnd%0d_rx got=%h exp=%h", it, OUTCOMING_DATA, exp_rx);
         end
         checks++;
         if ({RX_FULL, OVERRUN} !== 2'b10) begin
            errors++;
            $display("FAIL rnd%0d_flags got=%b exp=10", it, {RX_FULL, OVERRUN});
         end
         checks++;
         if (m_rx - m_fall != 17 * h) begin
            errors++;
            $display("FAIL rnd%0d_rx_lat got=%0d exp=%0d", it, m_rx - m_fall, 17 * h);
         end
      end
   endtask

   task automatic test_tx_full;
      set_mode(1'b0, 1'b0, 1'b0, 8'd1);
      loopb = 1'b1;
      @(negedge CLK);
      WRITE = 1'b1;
      INCOMING_DATA = 8'h55;
      CS_SEL = 2'd1;
      @(negedge CLK);
      INCOMING_DATA = 8'h66;
      @(negedge CLK);
      WRITE = 1'b0;
      watch(50, 1'b0, 1'b0, 8'h00);
      checks++;
      if (OUTCOMING_DATA !== 8'h55) begin
         errors++; $display("FAIL txfull_data got=%h exp=55", OUTCOMING_DATA);
      end
      checks++;
      if (m_rises != 1 || m_edges != 16) begin
         errors++;
         $display("FAIL txfull_frames got=%0d/%0d exp=1/16", m_rises, m_edges);
      end
      checks++;
      if ({TX_FULL, BUSY} !== 2'b00) begin
         errors++; $display("FAIL txfull_idle got=%b exp=00", {TX_FULL, BUSY});
      end
   endtask

   task automatic test_read_collision;
      set_mode(1'b0, 1'b0, 1'b0, 8'd1);
      loopb = 1'b1;
      write_word(8'h12, 2'd3);
      watch(40, 1'b0, 1'b0, 8'h00);
      write_word(8'h9C, 2'd3);
      repeat (34) @(negedge CLK);
      checks++;
      if (OUTCOMING_DATA !== 8'h12 || RX_FULL !== 1'b1) begin
         errors++;
         $display("FAIL coll_pre got=%h/%b exp=12/1", OUTCOMING_DATA, RX_FULL);
      end
      READ = 1'b1;
      @(negedge CLK);
      READ = 1'b0;
      checks++;
      if ({RX_FULL, OVERRUN} !== 2'b10) begin
         errors++; $display("FAIL coll_flags got=%b exp=10", {RX_FULL, OVERRUN});
      end
      checks++;
      if (OUTCOMING_DATA !== 8'h9C) begin
         errors++; $display("FAIL coll_data got=%h exp=9c", OUTCOMING_DATA);
      end
      repeat (6) @(negedge CLK);
   endtask

   task automatic test_chain_same;
      set_mode(1'b0, 1'b0, 1'b0, 8'd1);
      loopb = 1'b1;
      write_word(8'h11, 2'd1);
      fork
         watch(90, 1'b0, 1'b0, 8'h00);
         begin
            repeat (10) @(negedge CLK);
            write_word(8'h22, 2'd1);
         end
      join
      checks++;
      if (m_low != 72 || m_rises != 1) begin
         errors++;
         $display("FAIL chain_cs got=%0d/%0d exp=72/1", m_low, m_rises);
      end
      checks++;
      if (m_edges != 32) begin
         errors++; $display("FAIL chain_edges got=%0d exp=32", m_edges);
      end
      checks++;
      if ({RX_FULL, OVERRUN} !== 2'b11 || OUTCOMING_DATA !== 8'h22) begin
         errors++;
         $display("FAIL chain_rx got=%b/%h exp=11/22",
                  {RX_FULL, OVERRUN}, OUTCOMING_DATA);
      end
      @(negedge CLK);
      READ = 1'b1;
      @(negedge CLK);
      READ = 1'b0;
      checks++;
      if ({RX_FULL, OVERRUN} !== 2'b00) begin
         errors++; $display("FAIL read_clear got=%b exp=00", {RX_FULL, OVERRUN});
      end
   endtask

   task automatic test_chain_diff;
      loopb = 1'b1;
      write_word(8'h33, 2'd0);
      fork
         watch(100, 1'b0, 1'b0, 8'h00);
         begin
            repeat (10) @(negedge CLK);
            write_word(8'h44, 2'd3);
         end
      join
      checks++;
      if (m_cs !== 4'b1110 || m_low != 72) begin
         errors++;
         $display("FAIL chdiff_cs got=%b/%0d exp=1110/72", m_cs, m_low);
      end
      checks++;
      if (m_rises != 2 || !(m_gap >= 1)) begin
         errors++;
         $display("FAIL chdiff_gap got=%0d/%0d exp=2/>=1", m_rises, m_gap);
      end
      checks++;
      if (OUTCOMING_DATA !== 8'h44 || RX_FULL !== 1'b1) begin
         errors++;
         $display("FAIL chdiff_rx got=%h/%b exp=44/1", OUTCOMING_DATA, RX_FULL);
      end
   endtask

   task automatic test_clr_mid;
      logic pk;
      logic hit;
      logic wrote;
      int   edges;
      loopb = 1'b1;
      write_word(8'h5A, 2'd2);
      pk = S_CLK; hit = 1'b0; wrote = 1'b0; edges = 0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(negedge CLK);
         WRITE = 1'b0;
         if (BUSY && S_CLK !== pk) edges++;
         pk = S_CLK;
         if (edges == 3 && !wrote) begin
            WRITE = 1'b1;
            INCOMING_DATA = 8'h77;
            CS_SEL = 2'd2;
            wrote = 1'b1;
         end
         if (edges == 7) hit = 1'b1;
      end
      WRITE = 1'b0;
      checks++;
      if (!hit) begin
         errors++; $display("FAIL clr_wait got=%0d edges exp=7", edges);
      end else begin
         checks++;
         if (TX_FULL !== 1'b1) begin
            errors++; $display("FAIL clr_pre_tx got=%b exp=1", TX_FULL);
         end
         CLR = 1'b1;
         @(negedge CLK);
         CLR = 1'b0;
         checks++;
         if (CS !== 4'hF || BUSY !== 1'b0) begin
            errors++; $display("FAIL clr_cs got=%b/%b exp=1111/0", CS, BUSY);
         end
         checks++;
         if ({TX_FULL, RX_FULL, OVERRUN} !== 3'b000 || OUTCOMING_DATA !== 8'h00) begin
            errors++;
            $display("FAIL clr_status got=%b/%h exp=000/00",
                     {TX_FULL, RX_FULL, OVERRUN}, OUTCOMING_DATA);
         end
         repeat (5) @(negedge CLK);
         checks++;
         if (BUSY !== 1'b0 || CS !== 4'hF) begin
            errors++; $display("FAIL clr_after got=%b/%b exp=0/1111", BUSY, CS);
         end
      end
   endtask

   initial begin
      CLR = 1'b1;
      WRITE = 1'b0;
      READ = 1'b0;
      INCOMING_DATA = 8'h00;
      CS_SEL = 2'd0;
      CPOL = 1'b0;
      CPHA = 1'b0;
      LSB_FIRST = 1'b0;
      DIV = 8'd0;
      loopb = 1'b1;
      in_drv = 1'b0;
      test_reset();
      test_basic();
      test_mode3();
      test_random();
      test_tx_full();
      test_read_collision();
      test_chain_same();
      test_chain_diff();
      test_clr_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master engine: the next generation of the team's SPI interface. It serialises host words of configurable width onto `OUT`/`S_CLK` and captures `IN`. It drives one of `NUM_CS` active-low chip selects and supports all four CPOL/CPHA modes, MSB- or LSB-first ordering, a programmable clock divider and back-to-back chained transfers. It sits between the host register interface and the SPI pads, and replaces the fixed 8-bit master path with one holding register and one receive register.

## Interface
Parameters:
- `DW`, 8: data word width in bits (≥2).
- `NUM_CS`, 4: number of chip-select lines (≥1).
- `DIV_W`, 8: width of the clock-divider input.

Ports:
- `CLK`  in  1  system clock. One clock only; every flop updates on its rising edge.
- `CLR`  in  1  reset, synchronous, active-high.
- `WRITE`  in  1  one-cycle request to load `INCOMING_DATA` and `CS_SEL` into the holding register.
- `INCOMING_DATA`  in  DW  transmit word.
- `CS_SEL`  in  max(1,clog2(NUM_CS))  chip-select index for the written word.
- `READ`  in  1  one-cycle acknowledge of the receive register.
- `OUTCOMING_DATA`  out  DW  receive register, always driven.
- `CPOL`, `CPHA`, `LSB_FIRST`  in  1 each  mode controls.
- `DIV`  in  DIV_W  half-period of `S_CLK` = `DIV`+1 `CLK` cycles (H).
- `S_CLK`  out  1  SPI clock.
- `OUT`  out  1  MOSI.
- `IN`  in  1  MISO.
- `CS`  out  NUM_CS  active-low chip selects; at most one low at a time.
- `BUSY`, `TX_FULL`, `RX_FULL`, `OVERRUN`  out  1 each  status.

## Operation
- Reset values: `CS` all 1, `S_CLK`=0, `OUT`=0, `OUTCOMING_DATA`=0, `BUSY`/`TX_FULL`/`RX_FULL`/`OVERRUN`=0, state IDLE, counters 0. Reset mid-transfer aborts immediately with no partial RX update.
- Holding register: `WRITE` with `TX_FULL`=0 captures data and `CS_SEL` and sets `TX_FULL`. `WRITE` with `TX_FULL`=1 is ignored; the held data is unchanged.
- `CPOL`, `CPHA`, `LSB_FIRST` and `DIV` are latched on SETUP entry. Changes during a transfer are ignored.
- States:
  - IDLE: `BUSY`=0, `CS` all 1, `S_CLK` follows `CPOL` with a one-cycle lag. If `TX_FULL`=1, go to SETUP.
  - SETUP (H cycles): load the shift register from the holding register and clear `TX_FULL`. Drive `CS[sel]` low and `BUSY`=1. Drive `OUT` with bit index 0: the MSB, or the LSB if `LSB_FIRST`=1.
  - XFER (2·DW·H cycles): `S_CLK` toggles at the end of every half-period, giving edges 1..2DW.
    - CPHA=0: sample `IN` on odd edge 2i+1; drive bit i on edge 2i for i≥1.
    - CPHA=1: drive bit i on edge 2i+1; sample on even edge 2i+2.
    - On the cycle of edge 2DW, copy the assembled word to `OUTCOMING_DATA` and set `RX_FULL`.
  - HOLD (H cycles): `S_CLK` rests at `CPOL` and `CS` stays low.
    - If `TX_FULL`=1 and the held `CS_SEL` equals the active select, go to SETUP with `CS` kept low (chained transfer).
    - Otherwise go to IDLE with `CS` high for at least 1 cycle.
- Receive rules:
  - If the word completes while `RX_FULL`=1 and `READ`=0, overwrite the data and set sticky `OVERRUN`.
  - If `READ` and completion happen in the same cycle, `RX_FULL` stays 1 with the new data and no overrun is flagged.
  - `READ` alone clears `RX_FULL` and `OVERRUN` on the next edge.
- An out-of-range `CS_SEL` (≥`NUM_CS`) runs the transfer with all `CS` high.

## Timing
- Latency from `WRITE` (sampled at edge t):
  - `TX_FULL`=1 after t.
  - SETUP entered, `CS` low and `BUSY`=1 after t+1.
  - `CS` low for (2·DW+2)·H cycles.
  - `RX_FULL` rises (1+DW·2)·H cycles after SETUP entry.
- `TX_FULL` clears at SETUP entry, so the host may queue the next word for the whole transfer.
- A chained transfer adds no IDLE cycle between words.
- `DIV`=0 gives H=1, i.e. `S_CLK` = `CLK`/2. `DIV` saturates at all-ones, giving H=2^DIV_W with no wrap.
- Status outputs are registered and change only on `CLK` edges.

## Test plan
- Setup: DW=8, `DIV`=1, mode 0, MSB-first, `IN` looped to `OUT`.
  - Write 0xA5 to `CS_SEL`=2 → `CS`=4'b1011 for 36 cycles, 16 `S_CLK` edges, `OUTCOMING_DATA`=0xA5, `RX_FULL`=1.
- Mode 3, LSB-first, `DIV`=0, `IN` held at 1:
  - Write 0x3C → `OUT` sequence 0,0,1,1,1,1,0,0; `S_CLK` idles high; RX=0xFF.
- Chained transfer:
  - Write 0x11, then 0x22 during XFER, same `CS_SEL` → `CS` stays low across both words (72 cycles at `DIV`=1). `RX_FULL` and `OVERRUN` both set after the second word.
  - Repeat with different `CS_SEL` → `CS` high for ≥1 cycle between words.
- Write while `TX_FULL`=1: write 0x55 then 0x66 before SETUP → 0x55 is transmitted and 0x66 is dropped.
- Simultaneous `READ` and completion → `RX_FULL`=1, `OVERRUN`=0, new data visible.
- `CLR` asserted mid-XFER (edge 7) → next cycle `CS` all 1, `BUSY`=0, `RX_FULL`=0, `OUTCOMING_DATA`=0.
